// File: rtl/seq_det_ctrl.sv
// Word-level controller for an external serial 1011 detector (overlapping mode).
// Clears the detector, streams each word MSB-first, and returns count and first-hit position.
module seq_det_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4,
  parameter int unsigned POS_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             det_din,
  output logic             det_reset,
  input  logic             det_dout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count,
  output logic             out_hit,
  output logic [POS_W-1:0] out_pos,
  output logic             busy
);

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    SHIFT,
    DRAIN,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [POS_W-1:0]   k_q, k_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic               hit_q, hit_d;
  logic               sample_en;
  logic [POS_W-1:0]   sample_idx;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      k_q     <= '0;
      count_q <= '0;
      pos_q   <= '0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      k_q     <= k_d;
      count_q <= count_d;
      pos_q   <= pos_d;
      hit_q   <= hit_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    k_d        = k_q;
    count_d    = count_q;
    pos_d      = pos_q;
    hit_d      = hit_q;
    sample_en  = 1'b0;
    sample_idx = '0;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          shreg_d = in_data;
          count_d = '0;
          pos_d   = '0;
          hit_d   = 1'b0;
          state_d = CLR;
        end
      end
      CLR: begin
        k_d     = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        // det_dout is one cycle behind det_din, so this cycle reports bit k-1
        if (k_q != '0) begin
          sample_en  = 1'b1;
          sample_idx = k_q - 1'b1;
        end
        if (k_q == POS_W'(WIDTH - 1)) begin
          state_d = DRAIN;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DRAIN: begin
        sample_en  = 1'b1;
        sample_idx = POS_W'(WIDTH - 1);
        state_d    = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (sample_en && det_dout) begin
      if (count_q != '1) begin
        count_d = count_q + 1'b1;
      end
      if (!hit_q) begin
        hit_d = 1'b1;
        pos_d = sample_idx;
      end
    end
  end

  assign in_ready  = (state_q == IDLE) && !reset;
  assign out_valid = (state_q == DONE) && !reset;
  assign det_reset = reset || (state_q == CLR);
  assign det_din   = (state_q == SHIFT) && !reset && shreg_q[WIDTH-1];
  assign busy      = (state_q != IDLE);
  assign out_count = count_q;
  assign out_hit   = (count_q != '0);
  assign out_pos   = pos_q;

endmodule

// File: doc/seq_det_ctrl.md
Name: seq_det_ctrl

Overview:
Word-level controller and scheduler for the serial `seq_det` 1011 detector (overlapping mode).
- Accepts parallel words over a valid/ready handshake.
- Clears the detector before each word, then serializes the word MSB-first into `det_din`.
- Counts `det_dout` assertions and records the bit position of the first detection.
- Returns a per-word result over a second valid/ready handshake.
- Sits between a word-oriented producer/consumer and one external `seq_det` instance.

Parameters:
- WIDTH, 8, bits per input word; must be ≥ 4.
- CNT_W, 4, width of the detection counter; the counter saturates.
- POS_W, 3, width of the first-hit position field; 2**POS_W ≥ WIDTH.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  controller can accept a word.
- in_data  in  WIDTH  word; bit WIDTH-1 is sent first.
- det_din  out  1  serial bit to the detector `din`.
- det_reset  out  1  detector reset (to `seq_det` `reset`).
- det_dout  in  1  detector `dout`. Moore output: reflects the bit driven in the previous cycle.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_count  out  CNT_W  number of detections in the word.
- out_hit  out  1  out_count != 0.
- out_pos  out  POS_W  index (0 = MSB) of the last bit of the first detected 1011; 0 if no hit.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (synchronous; takes effect at the next posedge):
  - State goes to IDLE; count, pos and first-hit flag go to 0; shift register and bit counter go to 0.
  - out_valid=0, in_ready=0 while reset is high, det_din=0.
  - det_reset=1 during any cycle reset is high.
  - A reset asserted mid-word aborts the word; no result is produced.
- States: IDLE, CLR, SHIFT, DRAIN, DONE (registered FSM).
- IDLE:
  - in_ready=1.
  - When in_valid & in_ready: latch in_data, clear count/pos/flag, go to CLR.
- CLR: exactly one cycle; det_reset=1, det_din=0; go to SHIFT with bit index k=0.
- SHIFT: WIDTH cycles, k=0..WIDTH-1.
  - det_din = latched bit (WIDTH-1-k).
  - For k≥1, sample det_dout as the result of bit k-1.
  - After k=WIDTH-1, go to DRAIN.
- DRAIN: one cycle; det_din=0; sample det_dout as the result of bit WIDTH-1; go to DONE.
- Sample rule (applies to every sample in SHIFT and DRAIN):
  - If det_dout=1: count = min(count+1, 2**CNT_W-1), saturating.
  - If this is the first hit: pos = index of the bit, flag set.
- DONE:
  - out_valid=1; out_count/out_hit/out_pos are stable and registered.
  - When out_ready: go to IDLE. out_valid deasserts the next cycle.
  - out_ready low holds DONE indefinitely (backpressure); in_ready stays 0.
- Outside CLR and reset: det_reset=0.
- Outside SHIFT: det_din=0.
- Latency: handshake at cycle t → CLR at t+1 → SHIFT at t+2..t+WIDTH+1 → DRAIN at t+WIDTH+2 → out_valid first high at t+WIDTH+3.
- Throughput: one word per WIDTH+4 cycles, given zero-wait out_ready.
- in_valid is ignored outside IDLE; there is no buffering.
- Simultaneous out_ready in DONE and in_valid: the new word is accepted no earlier than the following cycle, in IDLE.
- Detection state never carries across words because CLR clears the detector every word.

Test Plan:
- in_data=8'hB6 (10110110), out_ready=1 → out_count=2, out_hit=1, out_pos=3. out_valid rises exactly 11 cycles after the accept edge, and is high for 1 cycle.
- in_data=8'hBB (10111011, overlapping) → out_count=2, out_pos=3. in_data=8'h00, then 8'hFF → out_count=0, out_hit=0, out_pos=0 for each.
- Back-to-back: 8'hB6 then 8'h0B (00001011) with in_valid held high → second result out_count=1, out_pos=7. No cross-word detection. det_reset pulses once per word. in_ready is high only in IDLE.
- Backpressure: hold out_ready=0 for 20 cycles in DONE → out_valid and outputs stay stable, in_ready=0, det_din=0. Release → result consumed once.
- Reset mid-SHIFT (k=4 of 8'hB6) → next cycle: state IDLE, out_valid=0, det_reset=1 for the reset cycle, no result emitted. Next word 8'hB6 → out_count=2.
- CNT_W=1 instance, 8'hB6 → out_count=1 (saturated), out_hit=1, out_pos=3.
